// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stack_pkg
//  Description : Shared types, default sizing and helpers for the
//                stack/queue buffer (LIFO/FIFO run-time selectable).
//  Revision    : 1.0 - initial release
// ============================================================================
package stack_pkg;

    // Operating mode of the buffer
    typedef enum logic {
        MODE_LIFO = 1'b0,
        MODE_FIFO = 1'b1
    } mode_e;

    // Default geometry
    localparam int C_DEF_DATA_COUNT         = 8;
    localparam int C_DEF_DATA_WIDTH         = 16;
    localparam int C_DEF_ALMOST_FULL_LEVEL  = 6;
    localparam int C_DEF_ALMOST_EMPTY_LEVEL = 2;

    // Width needed to hold an occupancy value in the range 0..n
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_mem.sv
`default_nettype none
// ============================================================================
//  Module      : stack_mem
//  Description : One-write / one-read register array with a registered
//                (synchronous) read port. A read and a write to the same
//                address in the same cycle returns the old contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_mem #(
    parameter int DATA_COUNT = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DATA_COUNT];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage write; contents are deliberately left unreset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Registered read data, held until the next read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule : stack_mem
`default_nettype wire

// File: rtl/stack_queue_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : stack_queue_buffer
//  Description : Parametrised LIFO/FIFO buffer, mode chosen at run time
//                (changes only take effect while empty and not pushing).
//                Simultaneous push/pop, occupancy count, overflow and
//                underflow pulses. Optional watermark flags are built when
//                the macro STACK_WATERMARK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_queue_buffer
    import stack_pkg::*;
#(
    parameter int DATA_COUNT = C_DEF_DATA_COUNT,
    parameter int DATA_WIDTH = C_DEF_DATA_WIDTH
`ifdef STACK_WATERMARK_EN
    ,
    parameter int ALMOST_FULL_LEVEL  = C_DEF_ALMOST_FULL_LEVEL,
    parameter int ALMOST_EMPTY_LEVEL = C_DEF_ALMOST_EMPTY_LEVEL
`endif
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  mode,
    input  logic                                  push,
    input  logic                                  pop,
    input  logic [DATA_WIDTH-1:0]                 data_in,
    output logic [DATA_WIDTH-1:0]                 data_out,
    output logic                                  out_valid,
    output logic [count_width(DATA_COUNT)-1:0]    count,
    output logic                                  empty,
    output logic                                  full,
    output logic                                  overflow,
    output logic                                  underflow,
    output logic                                  active_mode
`ifdef STACK_WATERMARK_EN
    ,
    output logic                                  almost_full,
    output logic                                  almost_empty
`endif
);

    localparam int CW = count_width(DATA_COUNT);
    localparam int AW = $clog2(DATA_COUNT);

    localparam logic [CW-1:0] c_count_max = CW'(DATA_COUNT);
    localparam logic [AW-1:0] c_ptr_last  = AW'(DATA_COUNT - 1);

    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    mode_e         r_active_mode;
    logic          r_out_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_empty;
    logic          w_full;
    logic          w_pop_ok;
    logic          w_push_ok;
    logic [CW-1:0] w_count_next;
    logic [AW-1:0] w_top_addr;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;
    logic [AW-1:0] w_wr_ptr_inc;
    logic [AW-1:0] w_rd_ptr_inc;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_count_max);

    // A pop on an empty buffer is never honoured; a push into a full one
    // only goes through when a pop frees a slot in the same cycle.
    assign w_pop_ok  = pop && !w_empty;
    assign w_push_ok = push && (!w_full || w_pop_ok);

    // Top-of-stack index; only consumed when count > 0
    assign w_top_addr = AW'(r_count - CW'(1));

    assign w_wr_ptr_inc = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + AW'(1);
    assign w_rd_ptr_inc = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + AW'(1);

    // Address selection: LIFO works off the count, FIFO off the pointers.
    // In LIFO push+pop the popped top slot is overwritten in place.
    always_comb begin
        w_wr_addr = r_wr_ptr;
        w_rd_addr = r_rd_ptr;
        if (r_active_mode == MODE_LIFO) begin
            w_rd_addr = w_top_addr;
            w_wr_addr = w_pop_ok ? w_top_addr : AW'(r_count);
        end
    end

    // Next occupancy from the accepted request pair
    always_comb begin
        w_count_next = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Occupancy, pointers, mode and status pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_active_mode <= MODE_LIFO;
            r_out_valid   <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_out_valid <= w_pop_ok;
            r_overflow  <= push && !w_push_ok;
            r_underflow <= pop && w_empty;
            if (w_empty && !push) begin
                r_active_mode <= mode_e'(mode);
            end
            if (r_active_mode == MODE_FIFO) begin
                if (w_push_ok) begin
                    r_wr_ptr <= w_wr_ptr_inc;
                end
                if (w_pop_ok) begin
                    r_rd_ptr <= w_rd_ptr_inc;
                end
            end
        end
    end

    stack_mem #(
        .DATA_COUNT (DATA_COUNT),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (w_push_ok),
        .wr_addr (w_wr_addr),
        .wr_data (data_in),
        .rd_en   (w_pop_ok),
        .rd_addr (w_rd_addr),
        .rd_data (data_out)
    );

`ifdef STACK_WATERMARK_EN
    localparam logic [CW-1:0] c_af_level = CW'(ALMOST_FULL_LEVEL);
    localparam logic [CW-1:0] c_ae_level = CW'(ALMOST_EMPTY_LEVEL);

    logic r_almost_full;
    logic r_almost_empty;

    // Watermarks track the count being loaded on the same edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_count_next >= c_af_level);
            r_almost_empty <= (w_count_next <= c_ae_level);
        end
    end

    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
`endif

    assign count       = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign out_valid   = r_out_valid;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign active_mode = r_active_mode;

endmodule : stack_queue_buffer
`default_nettype wire

// File: tb/tb_stack_queue_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_queue_buffer
//  Description : Directed self-checking bench for stack_queue_buffer
//                (4 entries x 16 bits). Watermark checks are compiled in
//                when STACK_WATERMARK_EN is defined (levels 3 / 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_queue_buffer;

    localparam int DC = 4;
    localparam int DW = 16;

    logic          clock;
    logic          reset_n;
    logic          mode;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic [2:0]    count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;
    logic          active_mode;
`ifdef STACK_WATERMARK_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    int n_vec = 0;
    int n_err = 0;

    stack_queue_buffer #(
        .DATA_COUNT (DC),
        .DATA_WIDTH (DW)
`ifdef STACK_WATERMARK_EN
        ,
        .ALMOST_FULL_LEVEL  (3),
        .ALMOST_EMPTY_LEVEL (1)
`endif
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mode        (mode),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow),
        .active_mode (active_mode)
`ifdef STACK_WATERMARK_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests, then settle 1 time unit past the edge
    task automatic cycle(input logic p, input logic q, input logic [DW-1:0] d);
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clock);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [DW-1:0] exp);
        cycle(1'b0, 1'b1, '0);
        chk(tag, 32'(data_out), 32'(exp));
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    endtask

    logic [DW-1:0] fifo_words [3];

    initial begin
        fifo_words[0] = 16'hA0A0;
        fifo_words[1] = 16'hB0B0;
        fifo_words[2] = 16'hC0C0;
        reset_n = 1'b0;
        mode    = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        chk("rst_mode", 32'(active_mode), 32'd0);
`ifdef STACK_WATERMARK_EN
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_ae", 32'(almost_empty), 32'd1);
`endif
        reset_n = 1'b1;
        cycle(1'b0, 1'b0, '0);

        // ---------------- LIFO fill, overflow, drain ----------------
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 1'b0, 16'(i * 16'h1111));
            chk("lifo_fill_cnt", 32'(count), 32'(i));
`ifdef STACK_WATERMARK_EN
            chk("lifo_fill_af", 32'(almost_full), 32'(i >= 3));
            chk("lifo_fill_ae", 32'(almost_empty), 32'(i <= 1));
`endif
        end
        chk("lifo_full", 32'(full), 32'd1);
        cycle(1'b1, 1'b0, 16'h5555);
        chk("lifo_ovf", 32'(overflow), 32'd1);
        chk("lifo_ovf_cnt", 32'(count), 32'd4);
        cycle(1'b0, 1'b0, '0);
        chk("lifo_ovf_pulse", 32'(overflow), 32'd0);
        pop_expect("lifo_pop4", 16'h4444);
        pop_expect("lifo_pop3", 16'h3333);
        pop_expect("lifo_pop2", 16'h2222);
        pop_expect("lifo_pop1", 16'h1111);
        chk("lifo_empty", 32'(empty), 32'd1);
        cycle(1'b0, 1'b0, '0);
        chk("lifo_vld_pulse", 32'(out_valid), 32'd0);
        chk("lifo_dout_hold", 32'(data_out), 32'h1111);

        // ---------------- FIFO ordering across pointer wrap ----------------
        mode = 1'b1;
        cycle(1'b0, 1'b0, '0);
        chk("fifo_mode", 32'(active_mode), 32'd1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, fifo_words[i]);
            chk("fifo_cnt3", 32'(count), 32'd3);
            for (int i = 0; i < 3; i++) pop_expect("fifo_order", fifo_words[i]);
            chk("fifo_empty", 32'(empty), 32'd1);
        end

        // ---------------- FIFO full, simultaneous push+pop ----------------
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 16'(i));
        chk("fifo_full", 32'(full), 32'd1);
        cycle(1'b1, 1'b1, 16'h9999);
        chk("fifo_pp_dout", 32'(data_out), 32'h0001);
        chk("fifo_pp_cnt", 32'(count), 32'd4);
        chk("fifo_pp_ovf", 32'(overflow), 32'd0);
        pop_expect("fifo_pp_q2", 16'h0002);
        pop_expect("fifo_pp_q3", 16'h0003);
        pop_expect("fifo_pp_q4", 16'h0004);
        pop_expect("fifo_pp_new", 16'h9999);
        chk("fifo_pp_empty", 32'(empty), 32'd1);

        // ---------------- LIFO full, simultaneous push+pop ----------------
        mode = 1'b0;
        cycle(1'b0, 1'b0, '0);
        chk("lifo_mode", 32'(active_mode), 32'd0);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 16'(i));
        cycle(1'b1, 1'b1, 16'h9999);
        chk("lifo_pp_dout", 32'(data_out), 32'h0004);
        chk("lifo_pp_cnt", 32'(count), 32'd4);
        pop_expect("lifo_pp_new", 16'h9999);
        pop_expect("lifo_pp_s3", 16'h0003);
        pop_expect("lifo_pp_s2", 16'h0002);
        pop_expect("lifo_pp_s1", 16'h0001);

        // ---------------- Empty corner cases ----------------
        cycle(1'b0, 1'b1, '0);
        chk("unf_pulse", 32'(underflow), 32'd1);
        chk("unf_vld", 32'(out_valid), 32'd0);
        chk("unf_cnt", 32'(count), 32'd0);
        chk("unf_dout_hold", 32'(data_out), 32'h0001);
        cycle(1'b1, 1'b1, 16'h7777);
        chk("unf_pp_cnt", 32'(count), 32'd1);
        chk("unf_pp_pulse", 32'(underflow), 32'd1);
        chk("unf_pp_vld", 32'(out_valid), 32'd0);
        cycle(1'b1, 1'b0, 16'h8888);
        chk("unf_clear", 32'(underflow), 32'd0);

        // ---------------- Mode request ignored while non-empty ----------------
        mode = 1'b1;
        cycle(1'b0, 1'b0, '0);
        chk("mode_ignored", 32'(active_mode), 32'd0);
        mode = 1'b0;
        cycle(1'b1, 1'b1, 16'hABCD);
        chk("lifo_pp2_dout", 32'(data_out), 32'h8888);
        chk("lifo_pp2_cnt", 32'(count), 32'd2);
        pop_expect("lifo_pp2_new", 16'hABCD);
        pop_expect("lifo_pp2_old", 16'h7777);

        // ---------------- Asynchronous reset mid-stream ----------------
        mode = 1'b1;
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 16'h1234);
        cycle(1'b1, 1'b1, 16'h5678);
        chk("pre_rst_mode", 32'(active_mode), 32'd1);
        chk("pre_rst_vld", 32'(out_valid), 32'd1);
        push    = 1'b1;
        data_in = 16'hDEAD;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_mode", 32'(active_mode), 32'd0);
        chk("arst_dout", 32'(data_out), 32'd0);
        chk("arst_vld", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        chk("arst_hold_cnt", 32'(count), 32'd0);
        push    = 1'b0;
        mode    = 1'b0;
        reset_n = 1'b1;
        cycle(1'b1, 1'b0, 16'h4321);
        chk("post_rst_cnt", 32'(count), 32'd1);
        pop_expect("post_rst_pop", 16'h4321);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_stack_queue_buffer
`default_nettype wire

// File: doc/stack_queue_buffer.md
Name: stack_queue_buffer

Overview:
- Parametrised successor to the team's single-mode stack.
- Storage holds data_count words of data_width bits and runs as LIFO or FIFO, selected at run time.
- Supports simultaneous push/pop, provides occupancy count, and flags overflow/underflow.
- Sits between producer and consumer datapaths as a general-purpose buffer.

Parameters:
- data_count, 8, number of storage entries; any value >= 2, power of two not required.
- data_width, 16, bits per entry.
- almost_full_level, 6, almost_full asserts when count >= this value (STACK_WATERMARK_EN only).
- almost_empty_level, 2, almost_empty asserts when count <= this value (STACK_WATERMARK_EN only).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = LIFO, 1 = FIFO; request value, see mode rules.
- push  in  1  write request.
- pop  in  1  read request.
- data_in  in  data_width  write data.
- data_out  out  data_width  registered read data.
- out_valid  out  1  one-cycle pulse: data_out updated by an accepted pop.
- count  out  $clog2(data_count+1)  current occupancy.
- empty  out  1  count == 0.
- full  out  1  count == data_count.
- overflow  out  1  one-cycle pulse: rejected push.
- underflow  out  1  one-cycle pulse: rejected pop.
- active_mode  out  1  mode currently in effect.
- almost_full, almost_empty  out  1 each  only with STACK_WATERMARK_EN.

Behaviour:
- Reset (async assert, sync release):
  - count = 0, data_out = 0, out_valid = 0, overflow = 0, underflow = 0.
  - active_mode = 0 (LIFO); wr_ptr = rd_ptr = 0.
  - Storage contents are not reset.
- Mode rules:
  - active_mode loads mode at a clock edge only when empty = 1 and push = 0.
  - Otherwise the mode request is ignored; no error is raised.
- Push acceptance: accepted if not full, or if full with an accepted pop in the same cycle.
- Pop acceptance: accepted if not empty; pop when empty is always rejected, even with a simultaneous push.
- Rejected push: no state change; overflow pulses for 1 cycle.
- Rejected pop: no state change; underflow pulses for 1 cycle.
- Read latency: data_out and out_valid update at the same edge the pop is accepted. data_out holds its value until the next accepted pop.
- LIFO:
  - Push writes mem[count] and increments count.
  - Pop reads mem[count-1] and decrements count.
  - Push + pop with count > 0: data_out = old top, mem[count-1] = data_in, count unchanged. This also applies when full.
- FIFO:
  - Push writes mem[wr_ptr] and advances wr_ptr.
  - Pop reads mem[rd_ptr] and advances rd_ptr.
  - Pointers wrap from data_count-1 to 0.
  - Push + pop with count > 0: both accepted, count unchanged. When full, the freed slot is written.
- Push + pop when empty (either mode): push accepted, underflow pulses, count becomes 1.
- Reset mid-operation: immediate clear of all outputs listed above; any in-flight request is discarded.
- count never exceeds data_count and never wraps below 0.

Optional Feature:
- Macro: STACK_WATERMARK_EN.
- Defined:
  - almost_full is a register, = (next count >= almost_full_level).
  - almost_empty is a register, = (next count <= almost_empty_level).
  - Both update at the same edge as count.
  - Reset values: almost_full = 0, almost_empty = 1.
- Undefined: ports, parameters and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package stack_pkg:
  - mode enum: MODE_LIFO = 0, MODE_FIFO = 1.
  - Default width/depth constants.
  - Function for count width, $clog2(n+1).
- Sub-module stack_mem: 1-write/1-read synchronous-read register array (data_count x data_width).
- Top level stack_queue_buffer holds count, pointers, acceptance logic and flags.

Test Plan (data_count=4, data_width=16):
- LIFO: push 1111, 2222, 3333, 4444 -> full=1, count=4. Push 5555 -> overflow pulse, count stays 4. Pop x4 -> data_out 4444, 3333, 2222, 1111; empty=1.
- FIFO: set mode=1 while empty; push A0A0, B0B0, C0C0; pop x3 -> A0A0, B0B0, C0C0. Repeat 3 times to cross pointer wrap; ordering preserved.
- Simultaneous, LIFO full [1,2,3,4]: push 9999 + pop -> data_out 4, count 4. Next pop -> 9999.
- Simultaneous, FIFO full: push + pop -> head returned, count 4, new word emerges last.
- Empty + pop -> underflow pulse, out_valid=0. Empty + push + pop -> count=1, underflow pulse.
- Mode change with count=2 is ignored (active_mode unchanged). Drop reset_n mid-stream -> count=0 and empty=1 asynchronously, active_mode=0. With STACK_WATERMARK_EN: almost_full toggles at count=6, almost_empty at count=2 (data_count=8).
